// File: rtl/gray_code_subtractor_pipe.sv
// Two-stage valid/ready pipeline that subtracts Gray-coded operands with borrow-in
// and returns a Gray-coded difference plus borrow-out.
module gray_code_subtractor_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);

    // MSB-first prefix XOR: each binary bit depends on the one above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] bin;
        bin            = '0;
        bin[WIDTH-1]   = g[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            bin[WIDTH-1-k] = bin[WIDTH-k] ^ g[WIDTH-1-k];
        end
        return bin;
    endfunction

    logic             v1_q, v2_q;
    logic [WIDTH-1:0] a_bin_q, b_bin_q;
    logic             bi_q;
    logic [WIDTH-1:0] diff_q;
    logic             bo_q;

    logic             adv1, adv2;
    logic [WIDTH-1:0] a_bin_d, b_bin_d;
    logic [WIDTH:0]   sub_d;
    logic [WIDTH-1:0] d_bin;
    logic [WIDTH-1:0] diff_d;

    always_comb begin
        adv2    = !v2_q || out_ready;
        adv1    = !v1_q || adv2;
        a_bin_d = gray2bin(a);
        b_bin_d = gray2bin(b);
        // One extra bit: a negative result leaves its sign in sub_d[WIDTH], i.e. the borrow-out.
        sub_d   = {1'b0, a_bin_q} - {1'b0, b_bin_q} - (WIDTH+1)'(bi_q);
        d_bin   = sub_d[WIDTH-1:0];
        diff_d  = d_bin ^ (d_bin >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            a_bin_q <= '0;
            b_bin_q <= '0;
            bi_q    <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_bin_q <= a_bin_d;
                b_bin_q <= b_bin_d;
                bi_q    <= bi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                diff_q <= diff_d;
                bo_q   <= sub_d[WIDTH];
            end
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign diff      = diff_q;
    assign bo        = bo_q;

endmodule

// File: tb/tb_gray_code_subtractor_pipe.sv
// Directed-vector, backpressure, exhaustive-sweep and mid-operation reset checks
// for the Gray-code subtractor pipeline at WIDTH=4.
module tb_gray_code_subtractor_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bo;

    gray_code_subtractor_pipe #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bi       (bi),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bo       (bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t tv[8];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer subtraction on values decoded by cumulative shifts.
    function automatic logic [4:0] model(input logic [3:0] ga, input logic [3:0] gb, input logic gbi);
        int ia, ib, d, dm;
        ia = int'(ga ^ (ga >> 1) ^ (ga >> 2) ^ (ga >> 3));
        ib = int'(gb ^ (gb >> 1) ^ (gb >> 2) ^ (gb >> 3));
        d  = ia - ib - int'(gbi);
        dm = d & 15;
        dm = dm ^ (dm >> 1);
        return {(d < 0) ? 1'b1 : 1'b0, dm[3:0]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] expq[$];
        logic [4:0] e;
        logic [8:0] sv;
        int         idx, nrecv, cyc;

        tv[0] = '{4'b0111, 4'b0010, 1'b0, 4'b0011, 1'b0};
        tv[1] = '{4'b0010, 4'b0111, 1'b0, 4'b1001, 1'b1};
        tv[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b1};
        tv[3] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0};
        tv[4] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1};
        tv[5] = '{4'b0101, 4'b0001, 1'b1, 4'b0110, 1'b0};
        tv[6] = '{4'b0000, 4'b1000, 1'b0, 4'b0001, 1'b1};
        tv[7] = '{4'b1100, 4'b0100, 1'b1, 4'b0000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; bi = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", bo, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        // Directed vectors, one at a time, out_ready high.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = tv[i].a; b = tv[i].b; bi = tv[i].bi; in_valid = 1'b1;
            #1 check("vec_in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 1'b0;
            check("vec_lat1_valid", out_valid, 0);
            @(negedge clk);
            check("vec_lat2_valid", out_valid, 1);
            check($sformatf("vec%0d_diff", i), diff, tv[i].d);
            check($sformatf("vec%0d_bo", i), bo, tv[i].bo);
        end
        @(negedge clk);
        check("vec_drain_valid", out_valid, 0);

        // Backpressure: three back-to-back offers with out_ready low.
        out_ready = 1'b0;
        a = tv[0].a; b = tv[0].b; bi = tv[0].bi; in_valid = 1'b1;
        #1 check("bp_rdy0", in_ready, 1);
        @(negedge clk);
        a = tv[1].a; b = tv[1].b; bi = tv[1].bi;
        #1 check("bp_rdy1", in_ready, 1);
        @(negedge clk);
        a = tv[2].a; b = tv[2].b; bi = tv[2].bi;
        #1 check("bp_rdy2_blocked", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_diff0", diff, tv[0].d);
        @(negedge clk);
        check("bp_hold_rdy", in_ready, 0);
        check("bp_hold_diff", diff, tv[0].d);
        check("bp_hold_bo", bo, tv[0].bo);
        out_ready = 1'b1;
        #1 check("bp_release_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_r0_valid", out_valid, 1);
        check("bp_r1_diff", diff, tv[1].d);
        check("bp_r1_bo", bo, tv[1].bo);
        @(negedge clk);
        check("bp_r2_valid", out_valid, 1);
        check("bp_r2_diff", diff, tv[2].d);
        check("bp_r2_bo", bo, tv[2].bo);
        @(negedge clk);
        check("bp_empty", out_valid, 0);

        // Exhaustive sweep with random out_ready.
        idx = 0; nrecv = 0; cyc = 0;
        while (nrecv < 512 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 99) < 60);
            if (idx < 512) begin
                sv = 9'(idx);
                a = sv[8:5]; b = sv[4:1]; bi = sv[0]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, bi));
                idx++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("sweep_unexpected_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check($sformatf("sweep_res%0d", nrecv), {bo, diff}, e);
                end
                nrecv++;
            end
        end
        check("sweep_count", nrecv, 512);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("sweep_drained", out_valid, 0);

        // Reset with two results in flight.
        out_ready = 1'b0;
        a = tv[0].a; b = tv[0].b; bi = tv[0].bi; in_valid = 1'b1;
        @(negedge clk);
        a = tv[1].a; b = tv[1].b; bi = tv[1].bi;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_full_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid_drop", out_valid, 0);
        check("mr_diff", diff, 0);
        check("mr_bo", bo, 0);
        check("mr_in_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b1;
        rst_n = 1'b1;
        a = tv[5].a; b = tv[5].b; bi = tv[5].bi; in_valid = 1'b1;
        #1 check("mr_first_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_no_stale", out_valid, 0);
        @(negedge clk);
        check("mr_new_valid", out_valid, 1);
        check("mr_new_diff", diff, tv[5].d);
        check("mr_new_bo", bo, tv[5].bo);
        @(negedge clk);
        check("mr_final_empty", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_code_subtractor_pipe.md
GRAY_CODE_SUBTRACTOR_PIPE -- requirements
Module: gray_code_subtractor_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand and result width in bits, with legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set on a, b and bi is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-006 SHALL have port a, input, WIDTH bits: minuend, Gray-coded.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend, Gray-coded.
REQ-008 SHALL have port bi, input, 1 bit: borrow-in, binary weight 1.
REQ-009 SHALL have port out_valid, output, 1 bit: diff and bo hold a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 SHALL have port diff, output, WIDTH bits: difference, Gray-coded.
REQ-012 SHALL have port bo, output, 1 bit: borrow-out.

Function
REQ-013 SHALL define an input transfer as in_valid & in_ready at a rising edge, and an output transfer as out_valid & out_ready at a rising edge.
REQ-014 SHALL use a two-stage pipeline with one valid flag per stage (v1, v2) and no other state machine.
- Stage 1 registers gray-to-binary of a and b (a_bin, b_bin) plus bi.
- Stage 2 registers the Gray-coded difference and bo.
REQ-015 SHALL convert Gray to binary MSB-first: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i].
REQ-016 SHALL compute, in stage 2 from stage-1 registers, {bo, d_bin} = a_bin - b_bin - bi at WIDTH+1 bits, where bo = 1 exactly when a_bin < b_bin + bi.
REQ-017 SHALL set diff = d_bin XOR (d_bin >> 1), with d_bin taken modulo 2^WIDTH (wrap-around).
REQ-018 SHALL define stage-2 advance as adv2 = !v2 | out_ready, and stage-1 advance as adv1 = !v1 | adv2.
REQ-019 SHALL drive in_ready = adv1 combinationally; there SHALL be no combinational path from a, b, bi or in_valid to in_ready.
REQ-020 SHALL, when adv1 is true, load stage 1 from the inputs and set v1 = in_valid; otherwise stage 1 holds.
REQ-021 SHALL, when adv2 is true, load stage 2 from stage 1 and set v2 = v1; otherwise stage 2 holds.
REQ-022 SHALL have latency of exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-023 SHALL sustain one transfer per cycle under continuous valid and ready.
REQ-024 SHALL keep diff and bo stable while out_valid & !out_ready, with no drop, duplication or reordering.
REQ-025 SHALL, when the pipe is full and out_ready = 0, drive in_ready = 0.
REQ-026 SHALL handle simultaneous output and input transfers on a full pipe without a bubble.
REQ-027 SHALL hold data registers at their previous value when a stage loads with valid = 0 (no X propagation required).

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear v1, v2, all data registers, diff and bo to 0, so that out_valid = 0.
REQ-029 SHALL drive in_ready = 1 during and after reset.
REQ-030 SHALL discard in-flight results when reset is asserted mid-operation, with no output transfer of them after release.
REQ-031 SHALL accept an input on the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL cover basic subtract (WIDTH=4, out_ready = 1): a = 0111, b = 0010, bi = 0 -> two cycles later out_valid = 1, diff = 0011, bo = 0.
REQ-033 SHALL cover wrap-around: a = 0010, b = 0111, bi = 0 -> diff = 1001, bo = 1; then a = 0000, b = 0000, bi = 1 -> diff = 1000, bo = 1.
REQ-034 SHALL cover backpressure: with out_ready = 0, offer three operand sets back-to-back -> first two accepted, in_ready = 0 on the third, diff held stable; then out_ready = 1 -> all three results emerge in order, one per cycle.
REQ-035 SHALL cover an exhaustive sweep: all a, b in 0..15 with bi in {0,1} streamed back-to-back, with random out_ready toggling -> every result matches a binary reference model in order, 512 results, none lost.
REQ-036 SHALL cover reset mid-operation: with two results in flight, pulse rst_n low asynchronously between edges -> out_valid drops immediately, diff = 0000, bo = 0, and no stale result appears afterwards.
